// File: rtl/i2s_line_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_line_receiver_if
//  Description : Codec pin group and sample-pair valid/ready stream.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2s_line_receiver_if;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdout;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clr;

  // Receiver side: drives codec clocks and the sample stream.
  modport master (
    output audio_mclk,
    output audio_lrck,
    output audio_sck,
    input  audio_sdout,
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready,
    output overrun,
    input  overrun_clr
  );

  // Codec/consumer side.
  modport slave (
    input  audio_mclk,
    input  audio_lrck,
    input  audio_sck,
    output audio_sdout,
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready,
    input  overrun,
    output overrun_clr
  );
endinterface
`default_nettype wire

// File: rtl/i2s_line_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_line_receiver
//  Description : I2S capture path; generates codec clocks, deserializes 16-bit
//                L/R words and publishes each frame through valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_line_receiver #(
  parameter logic [3:0] SAMPLE_PHASE = 4'd8,
  parameter int         SKIP_FRAMES  = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  i2s_line_receiver_if.master io_bus
);

  localparam logic [3:0] c_skip_init = 4'(SKIP_FRAMES);

  typedef enum logic [0:0] {
    ST_SKIP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [8:0]  r_cnt;
  logic        r_sd_meta;
  logic        r_sd_s;
  logic        r_primed;
  logic [15:0] r_left_sh;
  logic [15:0] r_right_sh;
  logic [15:0] r_sample_left;
  logic [15:0] r_sample_right;
  logic        r_valid;
  logic        r_overrun;
  logic        r_pub_pend;
  logic [3:0]  r_skip;
  state_t      r_state;

  logic [4:0]  w_slot;
  logic [3:0]  w_phase;
  logic        w_strobe;
  logic        w_slot0_strobe;
  logic        w_complete;
  logic [15:0] w_left_hit;
  logic [15:0] w_right_hit;
  logic        w_accept;
  logic        w_publish_req;
  logic [3:0]  w_skip_nxt;
  state_t      w_state_nxt;

  assign w_slot         = r_cnt[8:4];
  assign w_phase        = r_cnt[3:0];
  assign w_strobe       = (w_phase == SAMPLE_PHASE);
  assign w_slot0_strobe = w_strobe && (w_slot == 5'd0);
  // The first slot-0 strobe after reset closes no frame.
  assign w_complete     = w_slot0_strobe && r_primed;

  assign io_bus.audio_mclk = r_cnt[1];
  assign io_bus.audio_sck  = r_cnt[3];
  assign io_bus.audio_lrck = r_cnt[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 9'd0;
      r_sd_meta <= 1'b0;
      r_sd_s    <= 1'b0;
      r_primed  <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 9'd1;
      r_sd_meta <= io_bus.audio_sdout;
      r_sd_s    <= r_sd_meta;
      if (w_slot0_strobe) begin
        r_primed <= 1'b1;
      end
    end
  end

  // One-bit I2S delay: left bit b sits in slot 16-b, right bit b in slot
  // (32-b) mod 32, so right LSB lands in slot 0 of the following frame.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bit_map
    localparam logic [4:0] c_left_slot  = 5'(16 - gi);
    localparam logic [4:0] c_right_slot = 5'((32 - gi) % 32);
    assign w_left_hit[gi]  = w_strobe && (w_slot == c_left_slot);
    assign w_right_hit[gi] = w_strobe && (w_slot == c_right_slot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_sh  <= 16'd0;
      r_right_sh <= 16'd0;
    end else begin
      r_left_sh  <= (r_left_sh  & ~w_left_hit)  | ({16{r_sd_s}} & w_left_hit);
      r_right_sh <= (r_right_sh & ~w_right_hit) | ({16{r_sd_s}} & w_right_hit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SKIP;
      r_skip     <= c_skip_init;
      r_pub_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip     <= w_skip_nxt;
      r_pub_pend <= w_publish_req;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_skip_nxt    = r_skip;
    w_publish_req = 1'b0;
    case (r_state)
      ST_SKIP: begin
        if (w_complete) begin
          if (r_skip <= 4'd1) begin
            w_skip_nxt  = 4'd0;
            w_state_nxt = ST_RUN;
          end else begin
            w_skip_nxt  = r_skip - 4'd1;
          end
        end
      end
      ST_RUN: begin
        w_publish_req = w_complete;
      end
      default: begin
        w_state_nxt = ST_SKIP;
      end
    endcase
  end

  assign w_accept = r_valid && io_bus.sample_ready;

  // A publish wins over an accept on the same edge; valid then stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_left  <= 16'd0;
      r_sample_right <= 16'd0;
      r_valid        <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (r_pub_pend) begin
        r_sample_left  <= r_left_sh;
        r_sample_right <= r_right_sh;
        r_valid        <= 1'b1;
      end else if (w_accept) begin
        r_valid        <= 1'b0;
      end
      if (r_pub_pend && r_valid && !io_bus.sample_ready) begin
        r_overrun <= 1'b1;
      end else if (io_bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign io_bus.sample_left  = r_sample_left;
  assign io_bus.sample_right = r_sample_right;
  assign io_bus.sample_valid = r_valid;
  assign io_bus.overrun      = r_overrun;

endmodule
`default_nettype wire
